// File: rtl/clock_time_ctrl.sv
// Digital-clock timekeeping core: hour/min/sec registers, 1 Hz advance,
// RUN -> SET_HR -> SET_MIN set-time machine, and 12/24-hour display formatting.
module clock_time_ctrl #(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       pulse_mode,
  input  logic       pulse_inc,
  input  logic       dis_hour,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       blink_hr,
  output logic       blink_min
);

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MS_W   = 6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  state_t            state;
  logic [HOUR_W-1:0] hour_q;
  logic [MS_W-1:0]   min_q;
  logic [MS_W-1:0]   sec_q;
  logic              phase_q;
  logic [HOUR_W-1:0] hour_disp;

  // Binary 0..59 to packed BCD tens/ones by repeated subtraction of ten.
  function automatic logic [7:0] to_bcd(input logic [MS_W-1:0] v);
    logic [3:0]      tens;
    logic [MS_W-1:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= MS_W'(10)) begin
        rem  = rem - MS_W'(10);
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Mode machine plus time registers; a mode transition always wins over inc
  // and clears the blink phase, while a tick is judged in the old state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      hour_q  <= HOUR_W'(INIT_HOUR);
      min_q   <= MS_W'(INIT_MIN);
      sec_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (tick_1hz) begin
            if (sec_q == MS_W'(59)) begin
              sec_q <= '0;
              if (min_q == MS_W'(59)) begin
                min_q  <= '0;
                hour_q <= (hour_q == HOUR_W'(23)) ? '0 : hour_q + HOUR_W'(1);
              end else begin
                min_q <= min_q + MS_W'(1);
              end
            end else begin
              sec_q <= sec_q + MS_W'(1);
            end
          end
          if (pulse_mode) begin
            state   <= ST_SET_HR;
            phase_q <= 1'b0;
          end
        end
        ST_SET_HR: begin
          if (pulse_mode) begin
            state   <= ST_SET_MIN;
            phase_q <= 1'b0;
          end else begin
            if (tick_1hz) phase_q <= ~phase_q;
            if (pulse_inc)
              hour_q <= (hour_q == HOUR_W'(23)) ? '0 : hour_q + HOUR_W'(1);
          end
        end
        ST_SET_MIN: begin
          if (pulse_mode) begin
            state   <= ST_RUN;
            sec_q   <= '0;
            phase_q <= 1'b0;
          end else begin
            if (tick_1hz) phase_q <= ~phase_q;
            if (pulse_inc)
              min_q <= (min_q == MS_W'(59)) ? '0 : min_q + MS_W'(1);
          end
        end
        default: begin
          state   <= ST_RUN;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  // 12-hour mapping: 0 shows as 12, 13..23 fold down by twelve.
  always_comb begin
    hour_disp = hour_q;
    if (!dis_hour) begin
      if (hour_q == '0)
        hour_disp = HOUR_W'(12);
      else if (hour_q > HOUR_W'(12))
        hour_disp = hour_q - HOUR_W'(12);
    end
  end

  assign hour_bcd  = to_bcd(MS_W'(hour_disp));
  assign min_bcd   = to_bcd(min_q);
  assign sec_bcd   = to_bcd(sec_q);
  assign pm        = ~dis_hour & (hour_q >= HOUR_W'(12));
  assign set_state = 2'(state);
  assign blink_hr  = (state == ST_SET_HR) & phase_q;
  assign blink_min = (state == ST_SET_MIN) & phase_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: the driver pushes model predictions,
// a monitor pops and compares one entry after every clock edge.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, pulse_mode, pulse_inc, dis_hour;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       pm, blink_hr, blink_min;
  logic [1:0] set_state;

  clock_time_ctrl #(.INIT_HOUR(0), .INIT_MIN(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .pulse_mode(pulse_mode),
    .pulse_inc(pulse_inc), .dis_hour(dis_hour), .hour_bcd(hour_bcd),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm), .set_state(set_state),
    .blink_hr(blink_hr), .blink_min(blink_min)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       pm;
    logic [1:0] st;
    logic       bh;
    logic       bm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: wall-clock time plus mode index and blink phase.
  int m_h, m_m, m_s, m_mode;
  bit m_phase;
  bit dh_r;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic exp_t predict(input bit dh);
    exp_t e;
    int   hd;
    hd   = dh ? m_h : ((m_h % 12 == 0) ? 12 : m_h % 12);
    e.hr = bcd(hd);
    e.mn = bcd(m_m);
    e.sc = bcd(m_s);
    e.pm = !dh && (m_h >= 12);
    e.st = 2'(m_mode);
    e.bh = (m_mode == 1) && m_phase;
    e.bm = (m_mode == 2) && m_phase;
    return e;
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_phase = 0;
  endtask

  task automatic advance_second();
    int total;
    total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
    m_h = total / 3600;
    m_m = (total / 60) % 60;
    m_s = total % 60;
  endtask

  task automatic model_apply(input bit t, input bit md, input bit inc);
    if (md) begin
      if (m_mode == 0 && t) advance_second();
      if (m_mode == 2) m_s = 0;
      m_mode  = (m_mode + 1) % 3;
      m_phase = 0;
    end else if (m_mode == 0) begin
      if (t) advance_second();
    end else begin
      if (t) m_phase = !m_phase;
      if (inc && m_mode == 1) m_h = (m_h + 1) % 24;
      if (inc && m_mode == 2) m_m = (m_m + 1) % 60;
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, then wait for the edge.
  task automatic step(input bit t, input bit md, input bit inc, input bit dh);
    @(negedge clk);
    tick_1hz = t; pulse_mode = md; pulse_inc = inc; dis_hour = dh;
    model_apply(t, md, inc);
    q.push_back(predict(dh));
    @(posedge clk);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_hour_bcd", hour_bcd, e.hr);
        chk("sb_min_bcd", min_bcd, e.mn);
        chk("sb_sec_bcd", sec_bcd, e.sc);
        chk("sb_pm", 8'(pm), 8'(e.pm));
        chk("sb_set_state", 8'(set_state), 8'(e.st));
        chk("sb_blink_hr", 8'(blink_hr), 8'(e.bh));
        chk("sb_blink_min", 8'(blink_min), 8'(e.bm));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; tick_1hz = 0; pulse_mode = 0; pulse_inc = 0; dis_hour = 0;
    dh_r = 0;
    model_reset();
    #1;
    chk("rst_hour_bcd", hour_bcd, 8'h12);
    chk("rst_min_bcd", min_bcd, 8'h00);
    chk("rst_sec_bcd", sec_bcd, 8'h00);
    chk("rst_pm", 8'(pm), 8'd0);
    chk("rst_set_state", 8'(set_state), 8'd0);
    chk("rst_blink", 8'({blink_hr, blink_min}), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Set 23:59, leave SET_MIN, then count up to 23:59:58.
    step(0, 1, 0, 0);
    repeat (23) step(0, 0, 1, 1'($urandom_range(0, 1)));
    step(0, 1, 0, 0);
    repeat (59) step(1'($urandom_range(0, 1)), 0, 1, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 58; i++) step(1, 0, 1'($urandom_range(0, 1)), 1);
    step(1, 0, 0, 1);
    #1 chk("dir_sec59", sec_bcd, 8'h59);
    step(1, 0, 0, 0);
    #1;
    chk("dir_roll_hour", hour_bcd, 8'h12);
    chk("dir_roll_min", min_bcd, 8'h00);
    chk("dir_roll_sec", sec_bcd, 8'h00);
    chk("dir_roll_pm", 8'(pm), 8'd0);

    // SET_HR: dial hour 13, check both display formats and blink toggling.
    step(0, 1, 0, 0);
    repeat (13) step(0, 0, 1, 0);
    #1;
    chk("dir_h13_12h", hour_bcd, 8'h01);
    chk("dir_h13_pm", 8'(pm), 8'd1);
    chk("dir_set_hr", 8'(set_state), 8'd1);
    step(0, 0, 0, 1);
    #1;
    chk("dir_h13_24h", hour_bcd, 8'h13);
    chk("dir_h13_pm24", 8'(pm), 8'd0);
    step(1, 0, 0, 1);
    #1 chk("dir_blink1", 8'(blink_hr), 8'd1);
    step(1, 0, 0, 1);
    #1 chk("dir_blink0", 8'(blink_hr), 8'd0);
    step(1, 0, 0, 1);
    #1;
    chk("dir_blink1b", 8'(blink_hr), 8'd1);
    chk("dir_frozen_sec", sec_bcd, 8'h00);

    // Mode and inc together: mode wins. Then wrap minutes in SET_MIN.
    step(0, 1, 1, 1);
    #1;
    chk("dir_modeinc_state", 8'(set_state), 8'd2);
    chk("dir_modeinc_hour", hour_bcd, 8'h13);
    repeat (59) step(0, 0, 1, 1);
    #1 chk("dir_min59", min_bcd, 8'h59);
    step(0, 0, 1, 1);
    #1;
    chk("dir_min_wrap", min_bcd, 8'h00);
    chk("dir_min_wrap_hour", hour_bcd, 8'h13);
    step(0, 1, 0, 1);
    #1;
    chk("dir_back_run", 8'(set_state), 8'd0);
    chk("dir_back_sec", sec_bcd, 8'h00);
    chk("dir_back_blink", 8'(blink_min), 8'd0);
    step(0, 0, 1, 1);
    #1 chk("dir_run_inc_ignored", min_bcd, 8'h00);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) dh_r = !dh_r;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, dh_r);
    end

    // Asynchronous reset while in SET_MIN, between clock edges.
    while (m_mode != 2) step(0, 1, 0, 0);
    repeat (3) step(1'($urandom_range(0, 1)), 0, 1, 0);
    @(negedge clk);
    tick_1hz = 0; pulse_mode = 0; pulse_inc = 0; dis_hour = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 8'(set_state), 8'd0);
    chk("arst_hour", hour_bcd, 8'h12);
    chk("arst_min", min_bcd, 8'h00);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_blink", 8'({blink_hr, blink_min}), 8'd0);
    model_reset();
    q.push_back(predict(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0, 0);
    #1 chk("arst_resume_sec", sec_bcd, 8'h03);

    repeat (3) step(0, 0, 0, 1);
    #2 chk("sb_drain", 8'(q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
